// File: rtl/reaper_pkg.sv
// Shared types and constants for the Reaper program-counter sequencer.
// Holds the run-state encoding and the error codes shown on the error LED path.
package reaper_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } pc_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_RETI = 2'b11;

endpackage : reaper_pkg

// File: rtl/reaper_return_stack.sv
// Hardware return-address LIFO for the Reaper PC unit.
// The pointer register doubles as the occupancy count; overflowing pushes and underflowing pops are dropped.
module reaper_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Push,
    input  logic                   Pop,
    input  logic [WIDTH-1:0]       Push_Data,
    output logic [WIDTH-1:0]       Top,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Full,
    output logic                   Empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    ptr_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    wr_idx_s;

    assign Full      = (ptr_r == CW'(DEPTH));
    assign Empty     = (ptr_r == {CW{1'b0}});
    assign do_push_s = Push & ~Full;
    assign do_pop_s  = Pop & ~Empty & ~do_push_s;
    assign top_idx_s = AW'(ptr_r - CW'(1));
    assign wr_idx_s  = ptr_r[AW-1:0];
    assign Top       = mem_r[top_idx_s];
    assign Count     = ptr_r;

    // Stack pointer / occupancy count.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ptr_r <= {CW{1'b0}};
        end else if (do_push_s) begin
            ptr_r <= ptr_r + CW'(1);
        end else if (do_pop_s) begin
            ptr_r <= ptr_r - CW'(1);
        end
    end

    // Entry storage; contents are not cleared by reset.
    always_ff @(posedge Clock) begin
        if (do_push_s) begin
            mem_r[wr_idx_s] <= Push_Data;
        end
    end

endmodule : reaper_return_stack

// File: rtl/reaper_pc_unit.sv
// Reaper program-counter sequencer: next-PC priority mux, run/halt/error FSM,
// saved interrupt PC and the shared return-address stack.
module reaper_pc_unit
    import reaper_pkg::*;
#(
    parameter int          PC_WIDTH     = 8,
    parameter int          STACK_DEPTH  = 8,
    parameter int unsigned RESET_VECTOR = 32'd0,
    parameter int unsigned INT_VECTOR   = 32'h0000_00F0
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Step_En,
    input  logic                         Halt,
    input  logic                         Resume,
    input  logic                         Branch_Taken,
    input  logic [PC_WIDTH-1:0]          Branch_Target,
    input  logic                         Jump,
    input  logic                         Call,
    input  logic [PC_WIDTH-1:0]          Jump_Target,
    input  logic                         Ret,
    input  logic                         Interrupt,
    input  logic                         Int_Return,
    output logic [PC_WIDTH-1:0]          PC,
    output logic [PC_WIDTH-1:0]          NextPC,
    output logic                         Halted,
    output logic                         Int_Active,
    output logic [$clog2(STACK_DEPTH):0] Stack_Count,
    output logic                         Err_Out,
    output logic [1:0]                   Err_Code
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_C = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] INT_PC_C   = PC_WIDTH'(INT_VECTOR);

    pc_state_e           state_r;
    pc_state_e           state_nxt_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_nxt_s;
    logic [PC_WIDTH-1:0] epc_r;
    logic [PC_WIDTH-1:0] epc_nxt_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic                int_active_r;
    logic                int_active_nxt_s;
    logic [1:0]          err_code_r;
    logic [1:0]          err_code_nxt_s;
    logic                halted_r;
    logic                err_out_r;
    logic                push_s;
    logic                pop_s;
    logic [PC_WIDTH-1:0] stack_top_s;
    logic                stack_full_s;
    logic                stack_empty_s;

    assign pc_inc_s = pc_r + PC_WIDTH'(1);

    reaper_return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .Clock     (Clock),
        .Reset     (Reset),
        .Push      (push_s),
        .Pop       (pop_s),
        .Push_Data (pc_inc_s),
        .Top       (stack_top_s),
        .Count     (Stack_Count),
        .Full      (stack_full_s),
        .Empty     (stack_empty_s)
    );

    // Next-state, next-PC and stack control; everything holds unless Step_En is high.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        epc_nxt_s        = epc_r;
        int_active_nxt_s = int_active_r;
        err_code_nxt_s   = err_code_r;
        push_s           = 1'b0;
        pop_s            = 1'b0;
        if (Step_En) begin
            case (state_r)
                ST_RUN: begin
                    // A fresh interrupt swallows the current instruction so it re-executes on return.
                    if (Interrupt && !int_active_r) begin
                        epc_nxt_s        = pc_r;
                        pc_nxt_s         = INT_PC_C;
                        int_active_nxt_s = 1'b1;
                    end else if (Int_Return) begin
                        if (int_active_r) begin
                            pc_nxt_s         = epc_r;
                            int_active_nxt_s = 1'b0;
                        end else begin
                            state_nxt_s    = ST_ERROR;
                            err_code_nxt_s = ERR_RETI;
                        end
                    end else if (Ret) begin
                        if (stack_empty_s) begin
                            state_nxt_s    = ST_ERROR;
                            err_code_nxt_s = ERR_UNF;
                        end else begin
                            pc_nxt_s = stack_top_s;
                            pop_s    = 1'b1;
                        end
                    end else if (Call) begin
                        if (stack_full_s) begin
                            state_nxt_s    = ST_ERROR;
                            err_code_nxt_s = ERR_OVF;
                        end else begin
                            pc_nxt_s = Jump_Target;
                            push_s   = 1'b1;
                        end
                    end else if (Jump) begin
                        pc_nxt_s = Jump_Target;
                    end else if (Branch_Taken) begin
                        pc_nxt_s = Branch_Target;
                    end else if (Halt) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        pc_nxt_s = pc_inc_s;
                    end
                end
                ST_HALTED: begin
                    // Waking by interrupt returns past the HALT instruction.
                    if (Interrupt && !int_active_r) begin
                        state_nxt_s      = ST_RUN;
                        epc_nxt_s        = pc_inc_s;
                        pc_nxt_s         = INT_PC_C;
                        int_active_nxt_s = 1'b1;
                    end else if (Resume) begin
                        state_nxt_s = ST_RUN;
                        pc_nxt_s    = pc_inc_s;
                    end else begin
                        state_nxt_s = ST_HALTED;
                    end
                end
                ST_ERROR: begin
                    state_nxt_s = ST_ERROR;
                end
                default: begin
                    state_nxt_s    = ST_ERROR;
                    err_code_nxt_s = err_code_r;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Sequencer state registers; outputs are registered alongside the state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_RUN;
            pc_r         <= RESET_PC_C;
            epc_r        <= {PC_WIDTH{1'b0}};
            int_active_r <= 1'b0;
            err_code_r   <= ERR_NONE;
            halted_r     <= 1'b0;
            err_out_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            epc_r        <= epc_nxt_s;
            int_active_r <= int_active_nxt_s;
            err_code_r   <= err_code_nxt_s;
            halted_r     <= (state_nxt_s == ST_HALTED);
            err_out_r    <= (state_nxt_s == ST_ERROR);
        end
    end

    assign PC         = pc_r;
    assign NextPC     = pc_inc_s;
    assign Halted     = halted_r;
    assign Int_Active = int_active_r;
    assign Err_Out    = err_out_r;
    assign Err_Code   = err_code_r;

endmodule : reaper_pc_unit

// File: doc/reaper_pc_unit.md
Name: reaper_pc_unit

Overview:
- Parametrised program-counter sequencer for the Reaper processor.
- Replaces the fixed 8-bit PC+1 / branch-AND / stack-mux glue with one sequential block.
- Selects the next PC from sequential, branch, jump, call, return and interrupt sources.
- Owns a hardware return-address stack, the saved interrupt PC, and the halt/error run state that drives the top-level error LED.

Parameters:
- PC_WIDTH, 8: width of PC and all target/return addresses.
- STACK_DEPTH, 8: return-stack entries; power of two, >=2.
- RESET_VECTOR, 0: PC value after reset.
- INT_VECTOR, 'hF0: PC loaded on interrupt entry (truncated to PC_WIDTH).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Step_En  in  1  PC update strobe; no state changes when 0.
- Halt  in  1  current instruction is HALT.
- Resume  in  1  leave HALTED state.
- Branch_Taken  in  1  branch condition already ANDed with ALU_True.
- Branch_Target  in  PC_WIDTH  branch destination.
- Jump  in  1  unconditional jump.
- Call  in  1  push PC+1 and jump.
- Jump_Target  in  PC_WIDTH  jump/call destination.
- Ret  in  1  pop return address into PC.
- Interrupt  in  1  level interrupt request.
- Int_Return  in  1  return from interrupt.
- PC  out  PC_WIDTH  current program counter.
- NextPC  out  PC_WIDTH  PC+1, combinational, wraps modulo 2^PC_WIDTH.
- Halted  out  1  state == HALTED.
- Int_Active  out  1  interrupt service in progress.
- Stack_Count  out  $clog2(STACK_DEPTH)+1  occupied stack entries.
- Err_Out  out  1  state == ERROR.
- Err_Code  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 Int_Return without Int_Active.

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - PC=RESET_VECTOR, state RUN, Int_Active=0, EPC=0.
  - Stack_Count=0, Err_Out=0, Err_Code=00.
  - Stack contents need not be cleared.
- States and transitions:
  - RUN, HALTED, ERROR; all transitions happen only on edges where Step_En=1.
  - All updates are registered; PC changes on the edge after the inputs, with one cycle of latency.
- RUN priority (highest first):
  1. Interrupt & !Int_Active: EPC<=PC, PC<=INT_VECTOR, Int_Active<=1. All other control inputs that cycle are ignored, so the instruction re-executes after return.
  2. Int_Return: if Int_Active, PC<=EPC and Int_Active<=0; else go to ERROR with code 11.
  3. Ret: if stack empty, go to ERROR with code 10 and PC held; else PC<=top, pop.
  4. Call: if stack full, go to ERROR with code 01 and PC held; else push NextPC, PC<=Jump_Target.
  5. Jump: PC<=Jump_Target.
  6. Branch_Taken: PC<=Branch_Target.
  7. Halt: PC held, go to HALTED.
  8. Otherwise: PC<=NextPC.
- HALTED:
  - PC held.
  - Resume -> RUN with PC<=NextPC.
  - Interrupt & !Int_Active -> RUN with EPC<=NextPC, PC<=INT_VECTOR, Int_Active<=1. Interrupt has priority over Resume.
- ERROR: PC, stack and EPC frozen; exit only via Reset.
- Stack rules:
  - Push and pop are never simultaneous, because Ret outranks Call.
  - A Call pushed inside an ISR shares the same stack.
- Nested interrupts:
  - Interrupt is ignored while Int_Active=1.
  - A level still high after Int_Return is taken again on the next enabled edge.

Decomposition:
- Shared package reaper_pkg holds:
  - state encoding (RUN=2'd0, HALTED=2'd1, ERROR=2'd2);
  - Err_Code constants (ERR_NONE, ERR_OVF, ERR_UNF, ERR_RETI).
- Sub-module reaper_return_stack (params WIDTH, DEPTH):
  - ports: Clock, Reset, Push, Pop, Push_Data, Top, Count, Full, Empty;
  - synchronous LIFO with a pointer register;
  - when Full, Push is ignored internally;
  - when Empty, Pop is ignored internally.
- All remaining logic (next-PC priority mux, FSM, EPC) sits in reaper_pc_unit.

Test Plan:
- Sequential and wrap: PC_WIDTH=8, Step_En=1 for 260 cycles -> PC counts 0..255, then 0, 1, 2, 3; NextPC always PC+1 mod 256.
- Call/return: at PC=0x10, Call to 0x40 -> PC=0x40, Stack_Count=1; then Ret -> PC=0x11, Stack_Count=0.
- Overflow: STACK_DEPTH=4, five nested Calls -> after the fifth, Err_Out=1, Err_Code=01, Stack_Count=4, PC frozen for 10 further cycles until Reset.
- Underflow: Ret with empty stack -> Err_Code=10, Err_Out=1; later Reset low mid-cycle -> PC=0 and Err_Out=0 immediately, without waiting for a clock edge.
- Interrupt with simultaneous Jump: at PC=0x20, Interrupt=1 and Jump=1 -> PC=0xF0, Int_Active=1; second Interrupt ignored; Int_Return -> PC=0x20, Int_Active=0.
- Halt/wake and Step_En: Halt at PC=0x30 -> Halted=1, PC=0x30 held; Interrupt -> PC=0xF0; Int_Return -> PC=0x31. With Step_En=0 the PC never changes under any input.
